alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, sequential successor to the datapath's 16-bit combinational ALU. Executes the same 16-mode operation set at configurable WIDTH. Single-cycle ops complete in one clock; MUL/DIV/MOD run on an iterative shift-add / restoring-divide engine behind a start/done handshake. Sits between the operand muxes and the writeback stage; the control unit stalls on `busy`.

## Interface
- `WIDTH`, 16: operand/result width, ≥4, power of two.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: accept an op when high in IDLE; ignored otherwise.
- `mode` input 4: operation select, sampled with `start`.
- `ain` input WIDTH: operand A, sampled with `start`.
- `bin` input WIDTH: operand B, sampled with `start`.
- `busy` output 1: high while an iterative op is in progress.
- `done` output 1: one-cycle pulse; `result`/flags valid from this cycle until the next `done`.
- `result` output WIDTH: low result word.
- `result_hi` output WIDTH: MUL high word; remainder for DIV; 0 for all other modes.
- `flag_zero` output 1: `result == 0`.
- `flag_neg` output 1: `result[WIDTH-1]`.
- `flag_carry` output 1: ADD carry-out / SUB borrow; 0 for other modes.
- `flag_ovf` output 1: signed overflow for ADD/SUB; 0 for other modes.
- `flag_div0` output 1: DIV/MOD with `bin == 0`.

## Operation
- Mode map: 0 zero, 1 ADD, 2 SUB (A−B), 3 AND, 4 OR, 5 XOR, 6 NOT A, 7 MUL, 8 DIV, 9 MOD, A SHL, B SHR (logical), C pass A, D pass B, E (A≠B), F (A<B unsigned). Compare results are 1 or 0, zero-extended.
- Arithmetic is unsigned modulo 2^WIDTH, except `flag_ovf`, which uses the signed interpretation.
- Shifts use the full `bin` value; if `bin ≥ WIDTH`, the result is 0.
- MUL produces a 2·WIDTH-bit product: `{result_hi, result}`.
- DIV: quotient goes to `result`, remainder to `result_hi`. MOD: remainder goes to `result`, `result_hi` is 0.
- Divide by zero (DIV/MOD with `bin == 0`): no iteration is started.
  - DIV returns `result` = all ones, `result_hi` = `ain`.
  - MOD returns `result` = `ain`.
  - `flag_div0` = 1.
- FSM states:
  - IDLE:
    - `start` with an iterative mode and nonzero divisor (DIV/MOD), or with MUL, → RUN, loading operands and setting counter = WIDTH.
    - `start` with any other mode computes the result, registers it, pulses `done`, and stays in IDLE.
  - RUN: one bit per cycle; counter decrements; at counter 1 → FIN.
  - FIN: registers `result`/flags, pulses `done`, → IDLE.
- `start` while `busy` is dropped: no queueing, no error.
- Operands are latched at accept; later changes to `ain`/`bin`/`mode` do not affect an op in flight.

## Timing
- Reset (`rst_n` low at a rising edge) forces: state IDLE, `busy` = 0, `done` = 0, `result` = 0, `result_hi` = 0, all flags 0 except `flag_zero` = 1.
- Reset mid-RUN aborts the operation; no `done` is produced.
- Single-cycle ops: `start` sampled at edge k; `done` and outputs valid in the cycle after edge k (latency 1).
- Iterative ops: `busy` is high from edge k to edge k+WIDTH+1. `done` pulses after edge k+WIDTH+1 (latency WIDTH+1, i.e. 17 cycles at WIDTH=16). `busy` and `done` are never both high.
- Back-to-back: a new `start` is accepted in the cycle `done` is high (state IDLE). Single-cycle ops can therefore issue every cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `alu_pkg`:
  - mode localparams (`ALU_ZERO` … `ALU_SLTU`);
  - FSM state encoding (IDLE/RUN/FIN);
  - helper function `is_iter(mode)`.
- Sub-module `alu_iter_core`: shift-add multiplier and restoring divider sharing one 2·WIDTH accumulator and the counter. Ports: `clk`, `rst_n`, `load`, `op`, `a`, `b` → `acc`, `last`.
- Top `alu_seq` holds the FSM, the single-cycle combinational datapath, the output/flag registers, and the div-by-zero bypass.

## Test plan
- WIDTH=16: ADD 0xFFFF+0x0001 → `result` 0x0000, zero=1, carry=1, ovf=0, `done` at latency 1.
- ADD 0x7FFF+0x0001 → 0x8000, neg=1, ovf=1. SUB 0x0003−0x0005 → 0xFFFE, carry (borrow)=1.
- MUL 0x1234×0x0100 → `result` 0x3400, `result_hi` 0x0012. `busy` high 17 cycles, `done` at latency 17. A second `start` mid-RUN is ignored.
- DIV 100/7 → `result` 14, `result_hi` 2. MOD 100/7 → `result` 2. DIV 5/0 → `result` 0xFFFF, `result_hi` 5, div0=1, latency 1.
- SHL 0x0001 by 15 → 0x8000. SHL by 16 → 0. SLTU 3<5 → 1. NE 7,7 → 0, zero=1.
- Reset asserted at cycle 5 of a MUL → no `done`, outputs at reset values; a new single-cycle op is accepted on the first cycle after reset release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: mode map, FSM states, flag
// bundle and the iterative-mode classifier.
package alu_pkg;

  localparam logic [3:0] ALU_ZERO  = 4'h0;
  localparam logic [3:0] ALU_ADD   = 4'h1;
  localparam logic [3:0] ALU_SUB   = 4'h2;
  localparam logic [3:0] ALU_AND   = 4'h3;
  localparam logic [3:0] ALU_OR    = 4'h4;
  localparam logic [3:0] ALU_XOR   = 4'h5;
  localparam logic [3:0] ALU_NOT   = 4'h6;
  localparam logic [3:0] ALU_MUL   = 4'h7;
  localparam logic [3:0] ALU_DIV   = 4'h8;
  localparam logic [3:0] ALU_MOD   = 4'h9;
  localparam logic [3:0] ALU_SHL   = 4'hA;
  localparam logic [3:0] ALU_SHR   = 4'hB;
  localparam logic [3:0] ALU_PASSA = 4'hC;
  localparam logic [3:0] ALU_PASSB = 4'hD;
  localparam logic [3:0] ALU_SNE   = 4'hE;
  localparam logic [3:0] ALU_SLTU  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic div0;
  } alu_flags_t;

  // MUL/DIV/MOD go to the iterative engine (DIV/MOD only with a nonzero divisor).
  function automatic logic is_iter(input logic [3:0] mode);
    return (mode == ALU_MUL) || (mode == ALU_DIV) || (mode == ALU_MOD);
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative engine: shift-add multiplier and restoring divider sharing one
// 2*WIDTH accumulator {hi, lo} and a bit counter.
//   MUL: lo starts as the multiplier, hi accumulates; result {hi, lo}.
//   DIV: lo starts as the dividend, hi is the partial remainder;
//        ends with hi = remainder, lo = quotient.
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               op,    // 0 = multiply, 1 = divide
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic               r_op;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_acc_nx;

  // One iteration step for whichever operation is loaded.
  always_comb begin
    w_hi     = r_acc[2*WIDTH-1:WIDTH];
    w_lo     = r_acc[WIDTH-1:0];
    // Multiply: conditionally add B into the high half, then shift the
    // whole {carry, hi, lo} right by one.
    w_sum    = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : '0);
    // Divide: shift the next dividend bit into the remainder and try to
    // subtract. The remainder stays below B, so WIDTH bits of difference suffice.
    w_sh     = {w_hi, w_lo[WIDTH-1]};
    w_ge     = (w_sh >= {1'b0, r_b});
    w_diff   = w_sh[WIDTH-1:0] - r_b;
    w_acc_nx = r_acc;
    if (r_op) begin
      if (w_ge) w_acc_nx = {w_diff, w_lo[WIDTH-2:0], 1'b1};
      else      w_acc_nx = {w_sh[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0};
    end else begin
      w_acc_nx = {w_sum, w_lo[WIDTH-1:1]};
    end
  end

  // Load operands on accept, then step once per cycle until the counter empties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_b   <= '0;
      r_op  <= 1'b0;
      r_cnt <= '0;
    end else if (load) begin
      r_acc <= {{WIDTH{1'b0}}, a};
      r_b   <= b;
      r_op  <= op;
      r_cnt <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      r_acc <= w_acc_nx;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign acc  = r_acc;
  assign last = (r_cnt == CW'(1));

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle datapath for the simple modes, iterative
// engine for MUL/DIV/MOD, registered result/flags.
//
// Handshake: `start` is sampled only when the FSM is IDLE (busy low) and
// latches mode/ain/bin on that edge; a start seen while busy is dropped.
// `done` is a one-cycle pulse marking the cycle the new result/flags first
// appear; they hold until the next `done`. The FSM is back in IDLE while
// `done` is high, so a new start may be presented in that same cycle.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_div0,
  output logic [1:0]       o_dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e         r_state;
  alu_state_e         w_state_nx;
  logic               r_busy;
  logic               r_done;
  logic [3:0]         r_mode;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  alu_flags_t         r_fl;

  logic               w_load;
  logic               w_cap_single;
  logic               w_cap_iter;
  logic               w_div0;
  logic               w_op_div;

  logic [2*WIDTH-1:0] w_acc;
  logic               w_last;

  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic               w_sh_big;
  logic [SHW-1:0]     w_sh_amt;
  logic [WIDTH-1:0]   w_s_res;
  logic [WIDTH-1:0]   w_s_hi;
  alu_flags_t         w_s_fl;

  logic [WIDTH-1:0]   w_i_res;
  logic [WIDTH-1:0]   w_i_hi;
  alu_flags_t         w_i_fl;

  assign w_div0   = ((mode == ALU_DIV) || (mode == ALU_MOD)) && (bin == '0);
  assign w_op_div = (mode != ALU_MUL);

  alu_iter_core #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .op    (w_op_div),
    .a     (ain),
    .b     (bin),
    .acc   (w_acc),
    .last  (w_last)
  );

  // State register; busy is registered from the next state so it is
  // high exactly while RUN/FIN are occupied.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_mode  <= ALU_ZERO;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != ST_IDLE);
      if (w_load) r_mode <= mode;
    end
  end

  // Next state and capture strobes.
  always_comb begin
    w_state_nx   = r_state;
    w_load       = 1'b0;
    w_cap_single = 1'b0;
    w_cap_iter   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (is_iter(mode) && !w_div0) begin
            w_load     = 1'b1;
            w_state_nx = ST_RUN;
          end else begin
            w_cap_single = 1'b1;
          end
        end
      end
      ST_RUN:  if (w_last) w_state_nx = ST_FIN;
      ST_FIN: begin
        w_cap_iter = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Single-cycle datapath, including the divide-by-zero bypass.
  always_comb begin
    w_add    = {1'b0, ain} + {1'b0, bin};
    w_sub    = {1'b0, ain} - {1'b0, bin};
    // Any bin bit at or above log2(WIDTH) means a shift of WIDTH or more.
    w_sh_big = |(bin >> SHW);
    w_sh_amt = bin[SHW-1:0];
    w_s_res  = '0;
    w_s_hi   = '0;
    w_s_fl   = '0;
    case (mode)
      ALU_ADD: begin
        w_s_res      = w_add[WIDTH-1:0];
        w_s_fl.carry = w_add[WIDTH];
        w_s_fl.ovf   = (ain[WIDTH-1] == bin[WIDTH-1]) && (w_add[WIDTH-1] != ain[WIDTH-1]);
      end
      ALU_SUB: begin
        w_s_res      = w_sub[WIDTH-1:0];
        w_s_fl.carry = w_sub[WIDTH];
        w_s_fl.ovf   = (ain[WIDTH-1] != bin[WIDTH-1]) && (w_sub[WIDTH-1] != ain[WIDTH-1]);
      end
      ALU_AND:   w_s_res = ain & bin;
      ALU_OR:    w_s_res = ain | bin;
      ALU_XOR:   w_s_res = ain ^ bin;
      ALU_NOT:   w_s_res = ~ain;
      ALU_DIV: begin
        if (w_div0) begin
          w_s_res     = '1;
          w_s_hi      = ain;
          w_s_fl.div0 = 1'b1;
        end
      end
      ALU_MOD: begin
        if (w_div0) begin
          w_s_res     = ain;
          w_s_fl.div0 = 1'b1;
        end
      end
      ALU_SHL:   w_s_res = w_sh_big ? '0 : (ain << w_sh_amt);
      ALU_SHR:   w_s_res = w_sh_big ? '0 : (ain >> w_sh_amt);
      ALU_PASSA: w_s_res = ain;
      ALU_PASSB: w_s_res = bin;
      ALU_SNE:   w_s_res[0] = (ain != bin);
      ALU_SLTU:  w_s_res[0] = (ain < bin);
      default:   w_s_res = '0;
    endcase
    w_s_fl.zero = (w_s_res == '0);
    w_s_fl.neg  = w_s_res[WIDTH-1];
  end

  // Map the finished accumulator onto result/result_hi for the latched mode.
  always_comb begin
    w_i_res = w_acc[WIDTH-1:0];
    w_i_hi  = w_acc[2*WIDTH-1:WIDTH];
    if (r_mode == ALU_MOD) begin
      w_i_res = w_acc[2*WIDTH-1:WIDTH];
      w_i_hi  = '0;
    end
    w_i_fl      = '0;
    w_i_fl.zero = (w_i_res == '0);
    w_i_fl.neg  = w_i_res[WIDTH-1];
  end

  // Output registers: load on either completion path, pulse done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done      <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_fl        <= '{zero: 1'b1, neg: 1'b0, carry: 1'b0, ovf: 1'b0, div0: 1'b0};
    end else begin
      r_done <= w_cap_single | w_cap_iter;
      if (w_cap_single) begin
        r_result    <= w_s_res;
        r_result_hi <= w_s_hi;
        r_fl        <= w_s_fl;
      end else if (w_cap_iter) begin
        r_result    <= w_i_res;
        r_result_hi <= w_i_hi;
        r_fl        <= w_i_fl;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign result_hi   = r_result_hi;
  assign flag_zero   = r_fl.zero;
  assign flag_neg    = r_fl.neg;
  assign flag_carry  = r_fl.carry;
  assign flag_ovf    = r_fl.ovf;
  assign flag_div0   = r_fl.div0;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq at WIDTH=16: directed vector table, hand sequences
// for mid-run start and reset abort, then random ops against a model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W  = 16;
  localparam int EW = 2 * W + 5;

  // ---------------- clock / reset ----------------
  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   mode  = 4'h0;
  logic [W-1:0] ain   = '0;
  logic [W-1:0] bin   = '0;
  logic         busy, done, flag_zero, flag_neg, flag_carry, flag_ovf, flag_div0;
  logic [W-1:0] result, result_hi;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .ain         (ain),
    .bin         (bin),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .result_hi   (result_hi),
    .flag_zero   (flag_zero),
    .flag_neg    (flag_neg),
    .flag_carry  (flag_carry),
    .flag_ovf    (flag_ovf),
    .flag_div0   (flag_div0),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_run  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    string        nm;
    logic [3:0]   m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [4:0]   fl;   // {zero, neg, carry, ovf, div0}
    int           off;  // rising edges from accept to the edge that raises done
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model from the operation rules, using plain integer arithmetic.
  function automatic logic [EW-1:0] model(input logic [3:0] m, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint modv = longint'(1) << W;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = (ua >= modv / 2) ? ua - modv : ua;
    longint sb = (ub >= modv / 2) ? ub - modv : ub;
    longint r = 0, h = 0, sv = 0;
    logic c = 1'b0, o = 1'b0, d = 1'b0;
    case (m)
      4'h1: begin r = (ua + ub) % modv; c = (ua + ub) >= modv; sv = sa + sb; end
      4'h2: begin r = (ua - ub + modv) % modv; c = ua < ub; sv = sa - sb; end
      4'h3: r = longint'(a & b);
      4'h4: r = longint'(a | b);
      4'h5: r = longint'(a ^ b);
      4'h6: r = modv - 1 - ua;
      4'h7: begin r = (ua * ub) % modv; h = (ua * ub) / modv; end
      4'h8: if (ub == 0) begin r = modv - 1; h = ua; d = 1'b1; end
            else begin r = ua / ub; h = ua % ub; end
      4'h9: if (ub == 0) begin r = ua; d = 1'b1; end
            else r = ua % ub;
      4'hA: r = (ub >= W) ? 0 : (ua << ub) % modv;
      4'hB: r = (ub >= W) ? 0 : (ua >> ub);
      4'hC: r = ua;
      4'hD: r = ub;
      4'hE: r = (ua != ub) ? 1 : 0;
      4'hF: r = (ua < ub) ? 1 : 0;
      default: r = 0;
    endcase
    if (m == 4'h1 || m == 4'h2) o = (sv >= modv / 2) || (sv < -(modv / 2));
    return {W'(r), W'(h), (r == 0), (r >= modv / 2), c, o, d};
  endfunction

  function automatic int model_off(input logic [3:0] m, input logic [W-1:0] b);
    if (m == 4'h7 || ((m == 4'h8 || m == 4'h9) && b != 0)) return W + 1;
    return 0;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge. Presents one op for one edge, scrambles the inputs
  // while waiting (operands must be latched), optionally pokes a second start
  // at edge offset poke_at, then checks the result against the queue head.
  task automatic run_op(input string nm, input logic [3:0] m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eres,
                        input logic [W-1:0] ehi, input logic [4:0] efl,
                        input int eoff, input int poke_at);
    logic [EW-1:0] e;
    int off, busy_cnt;
    exp_q.push_back({eres, ehi, efl});
    start = 1'b1; mode = m; ain = a; bin = b;
    @(negedge clk);
    off = 0; busy_cnt = 0;
    while (!done && off < 60) begin
      if (busy) busy_cnt++;
      start = (off == poke_at);
      mode  = (off == poke_at) ? ALU_ADD : 4'($urandom_range(0, 15));
      ain   = W'($urandom);
      bin   = W'($urandom);
      @(negedge clk);
      off++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    chk({nm, " done"}, 64'(done), 64'(1));
    if (done) begin
      chk({nm, " result"},    64'(result),    64'(e[EW-1 -: W]));
      chk({nm, " result_hi"}, 64'(result_hi), 64'(e[W+4 -: W]));
      chk({nm, " flags"}, 64'({flag_zero, flag_neg, flag_carry, flag_ovf, flag_div0}),
          64'(e[4:0]));
      chk({nm, " done_edge"}, 64'(off), 64'(eoff));
      chk({nm, " busy_cycles"}, 64'(busy_cnt), 64'((eoff == 0) ? 0 : W + 1));
      chk({nm, " busy_with_done"}, 64'(busy), 64'(0));
    end
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, " busy"}, 64'(busy), 64'(0));
    chk({nm, " done"}, 64'(done), 64'(0));
    chk({nm, " result"}, 64'(result), 64'(0));
    chk({nm, " result_hi"}, 64'(result_hi), 64'(0));
    chk({nm, " flags"}, 64'({flag_zero, flag_neg, flag_carry, flag_ovf, flag_div0}),
        64'(5'b10000));
  endtask

  // Global time limit so the run always ends.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [EW-1:0] e;
    logic [3:0]    rm;
    logic [W-1:0]  ra, rb;
    int            done_seen;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;

    vecs.push_back('{"add_wrap",  ALU_ADD,   16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 5'b10100, 0});
    vecs.push_back('{"add_ovf",   ALU_ADD,   16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 5'b01010, 0});
    vecs.push_back('{"sub_borrow",ALU_SUB,   16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 5'b01100, 0});
    vecs.push_back('{"sub_ovf",   ALU_SUB,   16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 5'b00010, 0});
    vecs.push_back('{"mul",       ALU_MUL,   16'h1234, 16'h0100, 16'h3400, 16'h0012, 5'b00000, W + 1});
    vecs.push_back('{"div",       ALU_DIV,   16'd100,  16'd7,    16'd14,   16'd2,    5'b00000, W + 1});
    vecs.push_back('{"mod",       ALU_MOD,   16'd100,  16'd7,    16'd2,    16'd0,    5'b00000, W + 1});
    vecs.push_back('{"div0",      ALU_DIV,   16'd5,    16'd0,    16'hFFFF, 16'd5,    5'b01001, 0});
    vecs.push_back('{"mod0",      ALU_MOD,   16'd9,    16'd0,    16'd9,    16'd0,    5'b00001, 0});
    vecs.push_back('{"shl15",     ALU_SHL,   16'h0001, 16'd15,   16'h8000, 16'h0000, 5'b01000, 0});
    vecs.push_back('{"shl16",     ALU_SHL,   16'h0001, 16'd16,   16'h0000, 16'h0000, 5'b10000, 0});
    vecs.push_back('{"shr15",     ALU_SHR,   16'h8000, 16'd15,   16'h0001, 16'h0000, 5'b00000, 0});
    vecs.push_back('{"sltu",      ALU_SLTU,  16'd3,    16'd5,    16'd1,    16'd0,    5'b00000, 0});
    vecs.push_back('{"sne_eq",    ALU_SNE,   16'd7,    16'd7,    16'd0,    16'd0,    5'b10000, 0});
    vecs.push_back('{"and",       ALU_AND,   16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 5'b01000, 0});
    vecs.push_back('{"or",        ALU_OR,    16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000, 5'b00000, 0});
    vecs.push_back('{"xor",       ALU_XOR,   16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 5'b10000, 0});
    vecs.push_back('{"not",       ALU_NOT,   16'h0000, 16'h1234, 16'hFFFF, 16'h0000, 5'b01000, 0});
    vecs.push_back('{"passa",     ALU_PASSA, 16'h1234, 16'hABCD, 16'h1234, 16'h0000, 5'b00000, 0});
    vecs.push_back('{"passb",     ALU_PASSB, 16'h1234, 16'hABCD, 16'hABCD, 16'h0000, 5'b01000, 0});
    vecs.push_back('{"zero",      ALU_ZERO,  16'h1234, 16'hABCD, 16'h0000, 16'h0000, 5'b10000, 0});

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].nm, vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].hi,
             vecs[i].fl, vecs[i].off, -1);

    // A start presented mid-RUN must be dropped without disturbing the op.
    run_op("mul_poke", ALU_MUL, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 5'b00000, W + 1, 3);
    run_op("div_poke", ALU_DIV, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 5'b00000, W + 1, 10);

    // Reset during the fifth RUN cycle of a MUL aborts it.
    start = 1'b1; mode = ALU_MUL; ain = 16'h00FF; bin = 16'h00FF;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_state("mid_run_reset");
    rst_n = 1'b1;
    run_op("after_reset", ALU_ADD, 16'd2, 16'd3, 16'd5, 16'd0, 5'b00000, 0, -1);
    done_seen = 0;
    repeat (W + 8) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("aborted_no_done", 64'(done_seen), 64'(0));

    // Random ops, issued back to back, against the model.
    for (int i = 0; i < 150; i++) begin
      rm = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(0, 20));
        default: rb = W'($urandom);
      endcase
      e = model(rm, ra, rb);
      run_op($sformatf("rand%0d_m%0h", i, rm), rm, ra, rb, e[EW-1 -: W], e[W+4 -: W],
             e[4:0], model_off(rm, rb), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
